// File: rtl/mux_2x1_str_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared defaults for the structural 2:1 mux slice.
//   MUX_WIDTH_DEF : default data width of a0/a1/y/y_q
//   MUX_CNT_W_DEF : default width of the select-toggle counter
//   (the counter only exists when MUX_SEL_CNT_EN is defined)
// ---------------------------------------------------------------------------
package mux_pkg;
    localparam int MUX_WIDTH_DEF = 1;
    localparam int MUX_CNT_W_DEF = 16;
endpackage

// File: rtl/mux_2x1_str_if.sv
// ---------------------------------------------------------------------------
// mux_2x1_str_if
//   Bundles the mux data path (y, s, a0, a1) for whoever drives the cell.
//   master : drives s/a0/a1, observes y
//   slave  : the mux side, observes s/a0/a1, drives y
//   The cell itself keeps discrete ports in the fixed order (y, s, a0, a1),
//   so an instance hooks up to this bundle field by field.
// ---------------------------------------------------------------------------
interface mux_2x1_str_if
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF
) ();
    logic [WIDTH-1:0] y;
    logic             s;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;

    modport master (output s, a0, a1, input  y);
    modport slave  (input  s, a0, a1, output y);
endinterface

// File: rtl/mux_2x1_str_bit.sv
// ---------------------------------------------------------------------------
// mux2_bit_str
//   One-bit 2:1 mux built only from gate primitives: y = (~s & a0) | (s & a1).
//   y  out 1 : mux output
//   s  in  1 : select (0 -> a0, 1 -> a1)
//   a0 in  1 : data when s=0
//   a1 in  1 : data when s=1
//   An X/Z select simply propagates through the gate model.
// ---------------------------------------------------------------------------
module mux2_bit_str (
    output wire y,
    input  wire s,
    input  wire a0,
    input  wire a1
);
    wire sn;
    wire t0;
    wire t1;

    not n0 (sn, s);
    and g0 (t0, sn, a0);
    and g1 (t1, s, a1);
    or  g2 (y, t0, t1);
endmodule

// File: rtl/mux_2x1_str.sv
// ---------------------------------------------------------------------------
// mux_2x1_str
//   WIDTH-bit structural 2:1 mux (y = s ? a1 : a0) with a registered copy.
//   y           out WIDTH : combinational output, independent of clk/rst
//   s           in  1     : select
//   a0          in  WIDTH : data when s=0
//   a1          in  WIDTH : data when s=1
//   clk         in  1     : rising-edge clock
//   rst         in  1     : synchronous active-high reset
//   y_q         out WIDTH : y registered, cleared by reset
//   sel_toggles out CNT_W : saturating count of select changes
//                           (present only when MUX_SEL_CNT_EN is defined)
//   Optional feature macro: MUX_SEL_CNT_EN
// ---------------------------------------------------------------------------
module mux_2x1_str
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF,
    parameter int CNT_W = MUX_CNT_W_DEF
) (
    output wire  [WIDTH-1:0] y,
    input  logic             s,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] y_q
`ifdef MUX_SEL_CNT_EN
    ,
    output logic [CNT_W-1:0] sel_toggles
`endif
);
    // Reject degenerate configurations at elaboration time.
    if (WIDTH < 1) begin : g_bad_width
        $error("mux_2x1_str: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mux_2x1_str: CNT_W must be >= 1");
    end

    // One gate-level cell per bit; y is never touched by procedural code.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_bit_str u_bit (
            .y  (y[i]),
            .s  (s),
            .a0 (a0[i]),
            .a1 (a1[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) y_q <= '0;
        else     y_q <= y;
    end

`ifdef MUX_SEL_CNT_EN
    logic             s_d;      // select seen on the previous edge
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count select changes; hold at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if ((s != s_d) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_d   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s_d   <= s;
            cnt_q <= cnt_d;
        end
    end

    assign sel_toggles = cnt_q;
`endif
endmodule

// File: tb/tb_mux_2x1_str.sv
// ---------------------------------------------------------------------------
// tb_mux_2x1_str
//   Two instances: WIDTH=1 (default counter) and WIDTH=8 with CNT_W=2.
//   Inputs change on the falling edge; comb output is sampled 1 ns later,
//   registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_mux_2x1_str;
    import mux_pkg::*;

    localparam int W8   = 8;
    localparam int CW8  = 2;
    localparam int CW1  = MUX_CNT_W_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_2x1_str_if #(.WIDTH(1))  if1 ();
    mux_2x1_str_if #(.WIDTH(W8)) if8 ();

    logic [0:0]    yq1;
    logic [W8-1:0] yq8;
    logic [CW1-1:0] cnt1;
    logic [CW8-1:0] cnt8;

    mux_2x1_str #(.WIDTH(1), .CNT_W(CW1)) u_dut1 (
        .y   (if1.y),
        .s   (if1.s),
        .a0  (if1.a0),
        .a1  (if1.a1),
        .clk (clk),
        .rst (rst),
        .y_q (yq1)
`ifdef MUX_SEL_CNT_EN
        ,
        .sel_toggles (cnt1)
`endif
    );

    mux_2x1_str #(.WIDTH(W8), .CNT_W(CW8)) u_dut8 (
        .y   (if8.y),
        .s   (if8.s),
        .a0  (if8.a0),
        .a1  (if8.a1),
        .clk (clk),
        .rst (rst),
        .y_q (yq8)
`ifdef MUX_SEL_CNT_EN
        ,
        .sel_toggles (cnt8)
`endif
    );

`ifndef MUX_SEL_CNT_EN
    assign cnt1 = '0;
    assign cnt8 = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference rules written straight from the behaviour description.
    function automatic logic [W8-1:0] ref_mux(input logic s, input logic [W8-1:0] a0,
                                              input logic [W8-1:0] a1);
        return s ? a1 : a0;
    endfunction

    // Toggle count = number of value changes in the select history since
    // reset (history starts at 0), clipped at the counter's maximum.
    function automatic int ref_toggles(input logic hist[$], input int max_v);
        int   n = 0;
        logic prev = 1'b0;
        foreach (hist[k]) begin
            if (hist[k] != prev) n++;
            prev = hist[k];
        end
        return (n > max_v) ? max_v : n;
    endfunction

    typedef struct {
        logic s;
        logic a0;
        logic a1;
        logic y;
    } vec_t;

    vec_t vecs[8];
    logic hist1[$];
    logic hist8[$];
    logic [0:0]    exp_q1;
    logic [W8-1:0] exp_q8;

    initial begin
        // Exhaustive truth table for a single bit.
        vecs[0] = '{s:1'b0, a0:1'b0, a1:1'b0, y:1'b0};
        vecs[1] = '{s:1'b0, a0:1'b0, a1:1'b1, y:1'b0};
        vecs[2] = '{s:1'b0, a0:1'b1, a1:1'b0, y:1'b1};
        vecs[3] = '{s:1'b0, a0:1'b1, a1:1'b1, y:1'b1};
        vecs[4] = '{s:1'b1, a0:1'b0, a1:1'b0, y:1'b0};
        vecs[5] = '{s:1'b1, a0:1'b0, a1:1'b1, y:1'b1};
        vecs[6] = '{s:1'b1, a0:1'b1, a1:1'b0, y:1'b0};
        vecs[7] = '{s:1'b1, a0:1'b1, a1:1'b1, y:1'b1};

        if1.s = 1'b0; if1.a0 = '0; if1.a1 = '0;
        if8.s = 1'b0; if8.a0 = '0; if8.a1 = '0;

        // Reset state.
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_yq1", 32'(yq1), 32'd0);
        chk("rst_yq8", 32'(yq8), 32'd0);
`ifdef MUX_SEL_CNT_EN
        chk("rst_cnt8", 32'(cnt8), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
`endif

        // Truth table applied 10 ns apart, with reset held: y ignores rst.
        for (int i = 0; i < 8; i++) begin
            if1.s = vecs[i].s; if1.a0 = vecs[i].a0; if1.a1 = vecs[i].a1;
            #10;
            chk($sformatf("tt%0d_y", i), 32'(if1.y), 32'(vecs[i].y));
        end

        // Register path: release reset, s=1/a1=1 -> y now, y_q one edge later.
        @(negedge clk);
        rst = 1'b0;
        if1.s = 1'b1; if1.a0 = 1'b0; if1.a1 = 1'b1;
        #1;
        chk("reg_y_now", 32'(if1.y), 32'd1);
        chk("reg_yq_before", 32'(yq1), 32'd0);
        @(posedge clk); #1;
        chk("reg_yq_after", 32'(yq1), 32'd1);

        // Mid-run reset clears y_q while y keeps tracking.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_yq", 32'(yq1), 32'd0);
        chk("midrst_y",  32'(if1.y), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 8-bit steering.
        if8.a0 = 8'hA5; if8.a1 = 8'h3C; if8.s = 1'b0;
        #1;
        chk("w8_s0", 32'(if8.y), 32'h A5);
        if8.s = 1'b1;
        #1;
        chk("w8_s1", 32'(if8.y), 32'h 3C);
        if8.a0 = 8'h5A; if8.a1 = 8'h5A; if8.s = 1'b0;
        #1;
        chk("w8_eq_s0", 32'(if8.y), 32'h 5A);
        if8.s = 1'b1;
        #1;
        chk("w8_eq_s1", 32'(if8.y), 32'h 5A);

`ifdef MUX_SEL_CNT_EN
        // Saturating toggle counter (CNT_W=2): 1,2,3,3,3 then reset to 0.
        @(negedge clk);
        rst = 1'b1; if8.s = 1'b0;
        @(posedge clk); #1;
        chk("tog_rst0", 32'(cnt8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if8.s = ~if8.s;
            @(posedge clk); #1;
            chk($sformatf("tog_%0d", k), 32'(cnt8), 32'((k > 3) ? 3 : k));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("tog_rst1", 32'(cnt8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        // Randomized run against the reference rules; start from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        hist1.delete(); hist8.delete();
        exp_q1 = '0; exp_q8 = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 15) == 0);
            if1.s  = 1'($urandom); if1.a0 = 1'($urandom); if1.a1 = 1'($urandom);
            if8.s  = 1'($urandom); if8.a0 = 8'($urandom); if8.a1 = 8'($urandom);
            #1;
            chk("rnd_y1", 32'(if1.y), 32'(ref_mux(if1.s, 8'(if1.a0), 8'(if1.a1)) & 8'h01));
            chk("rnd_y8", 32'(if8.y), 32'(ref_mux(if8.s, if8.a0, if8.a1)));
            if (rst) begin
                exp_q1 = '0; exp_q8 = '0;
                hist1.delete(); hist8.delete();
            end else begin
                exp_q1 = 1'(ref_mux(if1.s, 8'(if1.a0), 8'(if1.a1)));
                exp_q8 = ref_mux(if8.s, if8.a0, if8.a1);
                hist1.push_back(if1.s);
                hist8.push_back(if8.s);
            end
            @(posedge clk); #1;
            chk("rnd_yq1", 32'(yq1), 32'(exp_q1));
            chk("rnd_yq8", 32'(yq8), 32'(exp_q8));
`ifdef MUX_SEL_CNT_EN
            chk("rnd_cnt1", 32'(cnt1), 32'(ref_toggles(hist1, (1 << CW1) - 1)));
            chk("rnd_cnt8", 32'(cnt8), 32'(ref_toggles(hist8, (1 << CW8) - 1)));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
